// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch response queue.
package fetch_pkg;
  localparam int FQ_DEPTH = 4;
  localparam int PC_W     = 32;
  localparam int INST_W   = 32;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fq_entry_t;

  typedef struct packed {
    logic            stale;
    logic [PC_W-1:0] pc;
  } fq_pend_t;
endpackage

// File: rtl/fq_fifo.sv
// Generic synchronous FIFO, pointer plus wrap bit for full/empty, with clear.
module fq_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = $bits(fq_entry_t),
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   cnt
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;

  assign cnt   = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Push into a full FIFO with a simultaneous pop overwrites the slot being read out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/fetch_resp_queue.sv
// Pairs instruction responses with issued PCs, drops pre-flush responses, buffers for decode.
// Optional same-cycle bypass from data_ok to decode: define FETCH_QUEUE_BYPASS_EN.
module fetch_resp_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic [31:0]       issue_pc,
  output logic              issue_allow,
  input  logic              data_ok,
  input  logic [31:0]       rdata,
  output logic              out_valid,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_inst,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  outstanding,
  output logic              resp_err
);
  localparam int AW = CNT_W - 1;

  logic [DEPTH-1:0] pq_stale;
  logic [PC_W-1:0]  pq_pc [DEPTH];
  logic [CNT_W-1:0] pq_wr, pq_rd, pq_cnt, dq_cnt;
  logic [CNT_W:0]   occ;
  logic             pq_push, pq_pop, pq_empty, fwd, proto_err;
  logic             dq_push, dq_pop, dq_empty;
  fq_pend_t         pq_head;
  fq_entry_t        dq_wdata, dq_rdata, head;

  assign pq_cnt   = pq_wr - pq_rd;
  assign pq_empty = (pq_cnt == '0);
  assign pq_head  = '{stale: pq_stale[pq_rd[AW-1:0]], pc: pq_pc[pq_rd[AW-1:0]]};

  // Every outstanding request owns a future DQ slot, so DQ can never overflow.
  assign occ         = {1'b0, pq_cnt} + {1'b0, dq_cnt};
  assign issue_allow = (occ < (CNT_W+1)'(DEPTH));

  assign pq_push   = issue_valid && issue_allow;
  assign pq_pop    = data_ok && !pq_empty;
  assign fwd       = pq_pop && !pq_head.stale && !flush;
  assign proto_err = (data_ok && pq_empty) || (issue_valid && !issue_allow);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pq_wr    <= '0;
      pq_rd    <= '0;
      pq_stale <= '0;
      resp_err <= 1'b0;
    end else begin
      if (pq_push) pq_wr <= pq_wr + CNT_W'(1);
      if (pq_pop)  pq_rd <= pq_rd + CNT_W'(1);
      // Bulk-kill everything older; the redirected fetch pushed this cycle stays live.
      if (flush)   pq_stale <= '1;
      if (pq_push) pq_stale[pq_wr[AW-1:0]] <= 1'b0;
      if (proto_err) resp_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (pq_push) pq_pc[pq_wr[AW-1:0]] <= issue_pc;
  end

  assign dq_wdata = '{pc: pq_head.pc, inst: rdata};
  assign dq_empty = (dq_cnt == '0);
  assign dq_pop   = !dq_empty && out_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic byp;
  assign byp       = dq_empty && fwd;
  assign dq_push   = fwd && !(byp && out_ready);
  assign head      = dq_empty ? dq_wdata : dq_rdata;
  assign out_valid = !dq_empty || byp;
`else
  assign dq_push   = fwd;
  assign head      = dq_rdata;
  assign out_valid = !dq_empty;
`endif

  fq_fifo #(.WIDTH($bits(fq_entry_t)), .DEPTH(DEPTH)) u_dq (
    .clk    (clk),
    .resetn (resetn),
    .push   (dq_push),
    .pop    (dq_pop),
    .clear  (flush),
    .wdata  (dq_wdata),
    .rdata  (dq_rdata),
    .cnt    (dq_cnt)
  );

  assign out_pc      = out_valid ? head.pc   : '0;
  assign out_inst    = out_valid ? head.inst : '0;
  assign outstanding = pq_cnt;
endmodule

// File: tb/tb_fetch_resp_queue.sv
// Directed table-driven bench for fetch_resp_queue (default DEPTH=4, registered path).
module tb_fetch_resp_queue;
  logic        clk = 1'b0;
  logic        resetn, flush, issue_valid, data_ok, out_ready;
  logic [31:0] issue_pc, rdata;
  logic        issue_allow, out_valid, resp_err;
  logic [31:0] out_pc, out_inst;
  logic [2:0]  outstanding;

  always #5 clk = ~clk;

  fetch_resp_queue dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .issue_valid(issue_valid), .issue_pc(issue_pc), .issue_allow(issue_allow),
    .data_ok(data_ok), .rdata(rdata),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_ready(out_ready),
    .outstanding(outstanding), .resp_err(resp_err)
  );

  typedef struct {
    logic        fl, iv;
    logic [31:0] ipc;
    logic        dok;
    logic [31:0] rd;
    logic        ordy;
    logic        ov;
    logic [31:0] opc, oinst;
    logic [2:0]  os;
    logic        ia, err;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic fl, iv, input logic [31:0] ipc, input logic dok,
                     input logic [31:0] rd, input logic ordy, input logic ov,
                     input logic [31:0] opc, oinst, input logic [2:0] os,
                     input logic ia, err);
    vec_t v;
    v.fl = fl; v.iv = iv; v.ipc = ipc; v.dok = dok; v.rd = rd; v.ordy = ordy;
    v.ov = ov; v.opc = opc; v.oinst = oinst; v.os = os; v.ia = ia; v.err = err;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic ov, input logic [31:0] opc, oinst,
                       input logic [2:0] os, input logic ia, err);
    n_vec++;
    if ({out_valid, out_pc, out_inst, outstanding, issue_allow, resp_err} !==
        {ov, opc, oinst, os, ia, err}) begin
      n_bad++;
      $display("FAIL %s: got ov=%0b pc=%h inst=%h os=%0d ia=%0b err=%0b, want ov=%0b pc=%h inst=%h os=%0d ia=%0b err=%0b",
               name, out_valid, out_pc, out_inst, outstanding, issue_allow, resp_err,
               ov, opc, oinst, os, ia, err);
    end
  endtask

  task automatic idle_inputs();
    flush = 0; issue_valid = 0; issue_pc = '0; data_ok = 0; rdata = '0; out_ready = 0;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later, before the rising edge.
  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(negedge clk);
      flush = vq[i].fl; issue_valid = vq[i].iv; issue_pc = vq[i].ipc;
      data_ok = vq[i].dok; rdata = vq[i].rd; out_ready = vq[i].ordy;
      #1;
      check($sformatf("row%0d", i), vq[i].ov, vq[i].opc, vq[i].oinst, vq[i].os, vq[i].ia, vq[i].err);
    end
  endtask

  int s1, s2, s3, s4, s5, s6, s7;

  initial begin
    resetn = 0;
    idle_inputs();
    // test 1: two in-order responses
    s1 = vq.size();
    add(0,0,0,           0,0,           1, 0,0,0,                    0,1,0);
    add(0,1,32'h1c000000,0,0,           1, 0,0,0,                    0,1,0);
    add(0,1,32'h1c000004,0,0,           1, 0,0,0,                    1,1,0);
    add(0,0,0,           1,32'h02800c0c,1, 0,0,0,                    2,1,0);
    add(0,0,0,           1,32'h0280100d,1, 1,32'h1c000000,32'h02800c0c,1,1,0);
    add(0,0,0,           0,0,           1, 1,32'h1c000004,32'h0280100d,0,1,0);
    add(0,0,0,           0,0,           1, 0,0,0,                    0,1,0);
    // test 2: fill to capacity with decode stalled
    s2 = vq.size();
    add(0,1,32'h1c000000,0,0,           0, 0,0,0,                    0,1,0);
    add(0,1,32'h1c000004,0,0,           0, 0,0,0,                    1,1,0);
    add(0,1,32'h1c000008,0,0,           0, 0,0,0,                    2,1,0);
    add(0,1,32'h1c00000c,0,0,           0, 0,0,0,                    3,1,0);
    add(0,0,0,           1,32'h11111111,0, 0,0,0,                    4,0,0);
    add(0,0,0,           1,32'h22222222,0, 1,32'h1c000000,32'h11111111,3,0,0);
    add(0,0,0,           1,32'h33333333,0, 1,32'h1c000000,32'h11111111,2,0,0);
    add(0,0,0,           1,32'h44444444,0, 1,32'h1c000000,32'h11111111,1,0,0);
    add(0,0,0,           0,0,           0, 1,32'h1c000000,32'h11111111,0,0,0);
    add(0,0,0,           0,0,           1, 1,32'h1c000000,32'h11111111,0,0,0);
    add(0,0,0,           0,0,           0, 1,32'h1c000004,32'h22222222,0,1,0);
    add(0,0,0,           0,0,           1, 1,32'h1c000004,32'h22222222,0,1,0);
    add(0,0,0,           0,0,           1, 1,32'h1c000008,32'h33333333,0,1,0);
    add(0,0,0,           0,0,           1, 1,32'h1c00000c,32'h44444444,0,1,0);
    add(0,0,0,           0,0,           1, 0,0,0,                    0,1,0);
    // test 3: flush with two outstanding, stale responses dropped
    s3 = vq.size();
    add(0,1,32'h1c000010,0,0,           1, 0,0,0,                    0,1,0);
    add(0,1,32'h1c000014,0,0,           1, 0,0,0,                    1,1,0);
    add(1,0,0,           0,0,           1, 0,0,0,                    2,1,0);
    add(0,1,32'h1c000100,0,0,           1, 0,0,0,                    2,1,0);
    add(0,0,0,           1,32'haaaa0000,1, 0,0,0,                    3,1,0);
    add(0,0,0,           1,32'hbbbb0000,1, 0,0,0,                    2,1,0);
    add(0,0,0,           1,32'h4c000020,1, 0,0,0,                    1,1,0);
    add(0,0,0,           0,0,           1, 1,32'h1c000100,32'h4c000020,0,1,0);
    add(0,0,0,           0,0,           1, 0,0,0,                    0,1,0);
    // test 4: flush + data_ok for head + new issue in one cycle, DQ non-empty
    s4 = vq.size();
    add(0,1,32'h1c000018,0,0,           0, 0,0,0,                    0,1,0);
    add(0,1,32'h1c000020,0,0,           0, 0,0,0,                    1,1,0);
    add(0,0,0,           1,32'h55555555,0, 0,0,0,                    2,1,0);
    add(1,1,32'h1c000200,1,32'h66666666,0, 1,32'h1c000018,32'h55555555,1,1,0);
    add(0,0,0,           0,0,           0, 0,0,0,                    1,1,0);
    add(0,0,0,           1,32'h77777777,0, 0,0,0,                    1,1,0);
    add(0,0,0,           0,0,           1, 1,32'h1c000200,32'h77777777,0,1,0);
    add(0,0,0,           0,0,           1, 0,0,0,                    0,1,0);
    // test 5 setup: 2 pending + 1 buffered
    s5 = vq.size();
    add(0,1,32'h1c000300,0,0,           0, 0,0,0,                    0,1,0);
    add(0,1,32'h1c000304,0,0,           0, 0,0,0,                    1,1,0);
    add(0,1,32'h1c000308,0,0,           0, 0,0,0,                    2,1,0);
    add(0,0,0,           1,32'h88888888,0, 0,0,0,                    3,1,0);
    add(0,0,0,           0,0,           0, 1,32'h1c000300,32'h88888888,2,1,0);
    // test 5 after reset release: fresh traffic
    s6 = vq.size();
    add(0,1,32'h1c000400,0,0,           0, 0,0,0,                    0,1,0);
    add(0,0,0,           1,32'h99999999,0, 0,0,0,                    1,1,0);
    add(0,0,0,           0,0,           1, 1,32'h1c000400,32'h99999999,0,1,0);
    add(0,0,0,           0,0,           1, 0,0,0,                    0,1,0);
    // test 6: protocol errors
    s7 = vq.size();
    add(0,0,0,           1,32'h12345678,0, 0,0,0,                    0,1,0);
    add(0,0,0,           0,0,           0, 0,0,0,                    0,1,1);
    add(0,1,32'h1c000500,0,0,           0, 0,0,0,                    0,1,1);
    add(0,1,32'h1c000504,0,0,           0, 0,0,0,                    1,1,1);
    add(0,1,32'h1c000508,0,0,           0, 0,0,0,                    2,1,1);
    add(0,1,32'h1c00050c,0,0,           0, 0,0,0,                    3,1,1);
    add(0,1,32'hdeadbeef,0,0,           0, 0,0,0,                    4,0,1);
    add(0,0,0,           1,32'ha1a1a1a1,1, 0,0,0,                    4,0,1);
    add(0,0,0,           1,32'ha2a2a2a2,1, 1,32'h1c000500,32'ha1a1a1a1,3,0,1);
    add(0,0,0,           1,32'ha3a3a3a3,1, 1,32'h1c000504,32'ha2a2a2a2,2,1,1);
    add(0,0,0,           1,32'ha4a4a4a4,1, 1,32'h1c000508,32'ha3a3a3a3,1,1,1);
    add(0,0,0,           0,0,           1, 1,32'h1c00050c,32'ha4a4a4a4,0,1,1);
    add(0,0,0,           0,0,           1, 0,0,0,                    0,1,1);

    #1;
    check("reset_state", 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    resetn = 1;

    run_rows(s1, s5);
    run_rows(s5, s6);

    // Asynchronous reset mid-cycle: outputs must clear before the next rising edge.
    #2;
    resetn = 0;
    #1;
    check("async_reset", 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    resetn = 1;
    idle_inputs();

    run_rows(s6, vq.size());

    @(negedge clk);
    idle_inputs();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
